// File: rtl/bus_mem_responder_pkg.sv
// Shared types for the CPU data-bus memory responder: access codes,
// posted-write FIFO entry layout and small decode helpers.
package bus_mem_responder_pkg;

    // Width and encoding of the data-bus access type (mirrors the bus header codes)
    localparam int MEM_ACCESS_W = 2;

    typedef enum logic [MEM_ACCESS_W-1:0] {
        MA_NONE = 2'd0,
        MA_R    = 2'd1,
        MA_W    = 2'd2,
        MA_X    = 2'd3
    } mem_access_e;

    // One posted IO write: byte address plus write data
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } io_entry_t;

    localparam io_entry_t IO_ENTRY_RESET = '{addr: 32'd0, data: 32'd0};

    // Reads and instruction fetches are serviced identically
    function automatic logic is_read(input logic [MEM_ACCESS_W-1:0] t);
        return (t == MA_R) || (t == MA_X);
    endfunction

    function automatic logic is_write(input logic [MEM_ACCESS_W-1:0] t);
        return (t == MA_W);
    endfunction

endpackage

// File: rtl/bus_mem_responder_io_post_fifo.sv
// Two-entry FIFO holding posted IO writes. A push while full is accepted
// only when a pop happens in the same cycle; pops while empty are ignored.
module io_post_fifo
    import bus_mem_responder_pkg::*;
(
    input  logic      clk,
    input  logic      res,
    input  logic      push,
    input  io_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output io_entry_t head
);

    io_entry_t  entry0_q, entry0_d;
    io_entry_t  entry1_q, entry1_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push_s;
    logic       do_pop_s;

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);
    assign head  = rd_ptr_q ? entry1_q : entry0_q;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        entry0_d  = entry0_q;
        entry1_d  = entry1_q;
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        if (do_push_s) begin
            if (wr_ptr_q) begin
                entry1_d = push_entry;
            end else begin
                entry0_d = push_entry;
            end
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!res) begin
            entry0_q <= IO_ENTRY_RESET;
            entry1_q <= IO_ENTRY_RESET;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the CPU data bus. RAM region is served from an
// internal word RAM; IO region goes to the io_* req/ack port, with IO writes
// posted through a two-entry FIFO that drains independently of the main FSM.
module bus_mem_responder
    import bus_mem_responder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int READ_WAIT = 1
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic [31:0]             db_addr,
    input  logic [31:0]             db_dataOut,
    input  logic                    db_io,
    input  logic [MEM_ACCESS_W-1:0] db_accessType,
    output logic [31:0]             db_dataIn,
    output logic                    db_ready,
    output logic                    bus_err,
    output logic [31:0]             io_addr,
    output logic [31:0]             io_wdata,
    output logic                    io_we,
    output logic                    io_req,
    input  logic                    io_ack,
    input  logic [31:0]             io_rdata
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RAM_RD   = 3'd1,
        S_IO_RD    = 3'd2,
        S_IO_WFULL = 3'd3,
        S_READY    = 3'd4
    } state_e;

    localparam int         RAM_WORDS = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_INIT = (READ_WAIT > 0) ? 4'(READ_WAIT - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ram_rd_q, ram_rd_d;
    logic [31:0] db_data_q, db_data_d;
    logic        ready_q;
    logic        err_q, err_d;

    logic [31:0]       ram_q [RAM_WORDS];
    logic [ADDR_W-1:0] db_idx_s;
    logic [31:0]       ram_rd_s;
    logic              in_range_s;
    logic              capture_s;
    logic              ram_we_s;

    logic      fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s, push_ok_s;
    io_entry_t push_entry_s, fifo_head_s;
    logic      wr_active_s, rd_active_s, io_rd_ack_s;

    assign db_idx_s   = db_addr[ADDR_W+1:2];
    assign in_range_s = !db_io && ((db_addr >> (ADDR_W + 2)) == 32'd0);
    assign ram_rd_s   = ram_q[db_idx_s];

    // IO port arbitration: posted writes drain first, a read only goes out once the FIFO is empty
    assign wr_active_s = !fifo_empty_s;
    assign rd_active_s = (state_q == S_IO_RD) && fifo_empty_s;
    assign fifo_pop_s  = wr_active_s && io_ack;
    assign io_rd_ack_s = rd_active_s && io_ack;
    assign push_ok_s   = !fifo_full_s || fifo_pop_s;

    assign io_req    = wr_active_s || rd_active_s;
    assign io_we     = wr_active_s;
    assign io_addr   = wr_active_s ? fifo_head_s.addr : addr_q;
    assign io_wdata  = wr_active_s ? fifo_head_s.data : 32'd0;

    assign db_dataIn = db_data_q;
    assign db_ready  = ready_q;
    assign bus_err   = err_q;

    io_post_fifo u_fifo (
        .clk        (clk),
        .res        (res),
        .push       (fifo_push_s),
        .push_entry (push_entry_s),
        .pop        (fifo_pop_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .head       (fifo_head_s)
    );

    // Main FSM next-state: capture/dispatch, read wait counting, IO completion
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ram_rd_d     = ram_rd_q;
        db_data_d    = db_data_q;
        err_d        = 1'b0;
        ram_we_s     = 1'b0;
        fifo_push_s  = 1'b0;
        push_entry_s = '{addr: addr_q, data: wdata_q};
        capture_s    = ((state_q == S_IDLE) || (state_q == S_READY)) && (db_accessType != MA_NONE);
        case (state_q)
            S_IDLE, S_READY: begin
                if (capture_s) begin
                    addr_d  = db_addr;
                    wdata_d = db_dataOut;
                    if (db_io) begin
                        if (is_write(db_accessType)) begin
                            push_entry_s = '{addr: db_addr, data: db_dataOut};
                            if (push_ok_s) begin
                                fifo_push_s = 1'b1;
                                state_d     = S_READY;
                            end else begin
                                state_d = S_IO_WFULL;
                            end
                        end else begin
                            state_d = S_IO_RD;
                        end
                    end else if (!in_range_s) begin
                        err_d   = 1'b1;
                        state_d = S_READY;
                        if (is_read(db_accessType)) begin
                            db_data_d = 32'd0;
                        end else begin
                            db_data_d = db_data_q;
                        end
                    end else if (is_write(db_accessType)) begin
                        // The write-back W is only visible for one cycle, so commit it now
                        ram_we_s = 1'b1;
                        state_d  = S_READY;
                    end else begin
                        if (READ_WAIT == 0) begin
                            db_data_d = ram_rd_s;
                            state_d   = S_READY;
                        end else begin
                            ram_rd_d = ram_rd_s;
                            cnt_d    = WAIT_INIT;
                            state_d  = S_RAM_RD;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RAM_RD: begin
                if (cnt_q == 4'd0) begin
                    db_data_d = ram_rd_q;
                    state_d   = S_READY;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_IO_RD: begin
                if (io_rd_ack_s) begin
                    db_data_d = io_rdata;
                    state_d   = S_READY;
                end else begin
                    state_d = S_IO_RD;
                end
            end
            S_IO_WFULL: begin
                if (push_ok_s) begin
                    fifo_push_s = 1'b1;
                    state_d     = S_READY;
                end else begin
                    state_d = S_IO_WFULL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and data registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            ram_rd_q  <= 32'd0;
            db_data_q <= 32'd0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ram_rd_q  <= ram_rd_d;
            db_data_q <= db_data_d;
            ready_q   <= (state_d == S_READY);
            err_q     <= err_d;
        end
    end

    // Word RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we_s && res) begin
            ram_q[db_idx_s] <= db_dataOut;
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed self-checking bench for bus_mem_responder (ADDR_W=10, READ_WAIT=2).
module tb_bus_mem_responder;
    import bus_mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        res;
    logic [31:0] db_addr;
    logic [31:0] db_dataOut;
    logic        db_io;
    logic [1:0]  db_accessType;
    logic [31:0] db_dataIn;
    logic        db_ready;
    logic        bus_err;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_we;
    logic        io_req;
    logic        io_ack;
    logic [31:0] io_rdata;

    int check_cnt = 0;
    int err_cnt   = 0;
    int lat;

    bus_mem_responder #(.ADDR_W(10), .READ_WAIT(2)) dut (
        .clk           (clk),
        .res           (res),
        .db_addr       (db_addr),
        .db_dataOut    (db_dataOut),
        .db_io         (db_io),
        .db_accessType (db_accessType),
        .db_dataIn     (db_dataIn),
        .db_ready      (db_ready),
        .bus_err       (bus_err),
        .io_addr       (io_addr),
        .io_wdata      (io_wdata),
        .io_we         (io_we),
        .io_req        (io_req),
        .io_ack        (io_ack),
        .io_rdata      (io_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle, then count cycles until db_ready (bounded)
    task automatic do_req(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                          input logic io, output int latency);
        db_accessType = t;
        db_addr       = a;
        db_dataOut    = d;
        db_io         = io;
        step();
        db_accessType = MA_NONE;
        db_dataOut    = 32'd0;
        latency = 1;
        while ((db_ready !== 1'b1) && (latency < 40)) begin
            step();
            latency++;
        end
    endtask

    initial begin
        res = 1'b0; db_addr = 32'd0; db_dataOut = 32'd0; db_io = 1'b0;
        db_accessType = MA_NONE; io_ack = 1'b0; io_rdata = 32'd0;
        step(); step();
        check_eq("rst_ready", {31'd0, db_ready}, 32'd0);
        check_eq("rst_data", db_dataIn, 32'd0);
        check_eq("rst_err", {31'd0, bus_err}, 32'd0);
        check_eq("rst_ioreq", {31'd0, io_req}, 32'd0);
        res = 1'b1;
        step();

        // 1: RAM write latency 1, read latency 1+READ_WAIT
        do_req(MA_W, 32'h10, 32'hDEADBEEF, 1'b0, lat);
        check_eq("t1_w_lat", lat, 32'd1);
        check_eq("t1_w_err", {31'd0, bus_err}, 32'd0);
        do_req(MA_R, 32'h10, 32'd0, 1'b0, lat);
        check_eq("t1_r_lat", lat, 32'd3);
        check_eq("t1_r_data", db_dataIn, 32'hDEADBEEF);
        step();
        check_eq("t1_pulse", {31'd0, db_ready}, 32'd0);

        // 2: write shown in the read's ready cycle is captured there
        do_req(MA_W, 32'h20, 32'hAAAA5555, 1'b0, lat);
        do_req(MA_R, 32'h20, 32'd0, 1'b0, lat);
        check_eq("t2_r_data", db_dataIn, 32'hAAAA5555);
        do_req(MA_W, 32'h20, 32'h11223344, 1'b0, lat);
        check_eq("t2_w_lat", lat, 32'd1);
        do_req(MA_R, 32'h20, 32'd0, 1'b0, lat);
        check_eq("t2_r2_data", db_dataIn, 32'h11223344);
        step(); step();

        // 3: posted IO writes, third stalls until the first ack
        do_req(MA_W, 32'h100, 32'h1, 1'b1, lat);
        check_eq("t3_w1_lat", lat, 32'd1);
        check_eq("t3_head1", io_addr, 32'h100);
        check_eq("t3_we1", {31'd0, io_we}, 32'd1);
        do_req(MA_W, 32'h104, 32'h2, 1'b1, lat);
        check_eq("t3_w2_lat", lat, 32'd1);
        db_accessType = MA_W; db_addr = 32'h108; db_dataOut = 32'h3; db_io = 1'b1;
        step();
        db_accessType = MA_NONE;
        check_eq("t3_stall_a", {31'd0, db_ready}, 32'd0);
        step();
        check_eq("t3_stall_b", {31'd0, db_ready}, 32'd0);
        check_eq("t3_still_head", io_addr, 32'h100);
        io_ack = 1'b1;
        step();
        check_eq("t3_w3_ready", {31'd0, db_ready}, 32'd1);
        check_eq("t3_head2", io_addr, 32'h104);
        check_eq("t3_wdata2", io_wdata, 32'h2);
        step();
        check_eq("t3_head3", io_addr, 32'h108);
        check_eq("t3_wdata3", io_wdata, 32'h3);
        step();
        check_eq("t3_drained", {31'd0, io_req}, 32'd0);
        io_ack = 1'b0;
        step();

        // 4: IO read waits behind posted writes
        do_req(MA_W, 32'h300, 32'h30, 1'b1, lat);
        do_req(MA_W, 32'h304, 32'h34, 1'b1, lat);
        db_accessType = MA_R; db_addr = 32'h200; db_io = 1'b1;
        step();
        db_accessType = MA_NONE;
        check_eq("t4_wr_first_we", {31'd0, io_we}, 32'd1);
        check_eq("t4_wr_first_addr", io_addr, 32'h300);
        io_ack = 1'b1;
        step();
        check_eq("t4_wr_second", io_addr, 32'h304);
        step();
        io_ack = 1'b0;
        check_eq("t4_rd_req", {31'd0, io_req}, 32'd1);
        check_eq("t4_rd_we", {31'd0, io_we}, 32'd0);
        check_eq("t4_rd_addr", io_addr, 32'h200);
        check_eq("t4_not_ready", {31'd0, db_ready}, 32'd0);
        io_rdata = 32'h12345678; io_ack = 1'b1;
        step();
        io_ack = 1'b0; io_rdata = 32'd0;
        check_eq("t4_ready", {31'd0, db_ready}, 32'd1);
        check_eq("t4_data", db_dataIn, 32'h12345678);
        check_eq("t4_req_low", {31'd0, io_req}, 32'd0);
        step();

        // 5: out-of-range RAM access
        do_req(MA_W, 32'h0, 32'h0BADC0DE, 1'b0, lat);
        do_req(MA_R, 32'h0010_0000, 32'd0, 1'b0, lat);
        check_eq("t5_r_lat", lat, 32'd1);
        check_eq("t5_r_err", {31'd0, bus_err}, 32'd1);
        check_eq("t5_r_data", db_dataIn, 32'd0);
        do_req(MA_W, 32'h0010_0000, 32'hCAFEF00D, 1'b0, lat);
        check_eq("t5_w_err", {31'd0, bus_err}, 32'd1);
        do_req(MA_R, 32'h0, 32'd0, 1'b0, lat);
        check_eq("t5_ram_kept", db_dataIn, 32'h0BADC0DE);
        check_eq("t5_ok_err", {31'd0, bus_err}, 32'd0);
        step();

        // 6: reset during a RAM read and during a pending IO read
        db_accessType = MA_R; db_addr = 32'h10; db_io = 1'b0;
        step();
        db_accessType = MA_NONE;
        res = 1'b0;
        step();
        res = 1'b1;
        check_eq("t6_rd_rst_ready", {31'd0, db_ready}, 32'd0);
        step();
        check_eq("t6_rd_rst_ready2", {31'd0, db_ready}, 32'd0);
        db_accessType = MA_R; db_addr = 32'h400; db_io = 1'b1;
        step();
        db_accessType = MA_NONE;
        check_eq("t6_io_req_up", {31'd0, io_req}, 32'd1);
        res = 1'b0;
        step();
        res = 1'b1;
        check_eq("t6_io_rst_req", {31'd0, io_req}, 32'd0);
        check_eq("t6_io_rst_ready", {31'd0, db_ready}, 32'd0);
        io_ack = 1'b1; io_rdata = 32'h55555555;
        step();
        io_ack = 1'b0; io_rdata = 32'd0;
        check_eq("t6_late_ack", {31'd0, db_ready}, 32'd0);
        do_req(MA_R, 32'h10, 32'd0, 1'b0, lat);
        check_eq("t6_after_lat", lat, 32'd3);
        check_eq("t6_after_data", db_dataIn, 32'hDEADBEEF);
        step();

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
